card_dealer: RTL and testbench
==============================

CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have no parameters; all widths fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request new game; sampled only in IDLE or DONE.
REQ-005 ext_card  input  4  external card value; present only with DEALER_EXT_CARD_EN.
REQ-006 pcard1, pcard2, pcard3  output  4 each  player cards dealt, 1..13 (0 = not dealt).
REQ-007 bcard1, bcard2, bcard3  output  4 each  banker cards dealt, same encoding.
REQ-008 pscore, bscore  output  4 each  hand scores 0..9, combinational from card registers.
REQ-009 player_win, banker_win  output  1 each  result; both high = tie; valid only while done=1.
REQ-010 done  output  1  high in DONE state; busy  output  1  high in any deal/eval state.

Function
REQ-011 Card face value SHALL be the card value for 1..9 and 0 for every other code (0, 10..15).
REQ-012 Hand score SHALL be (sum of face values of the hand's three card registers) mod 10, computed at 5-bit width before the modulo.
REQ-013 States: IDLE, DEAL_P1, DEAL_B1, DEAL_P2, DEAL_B2, EVAL, DEAL_P3, BANK_DEC, DEAL_B3, DONE.
REQ-014 IDLE or DONE with start=1 SHALL clear all six card registers to 0 and go to DEAL_P1 on the same edge.
REQ-015 Each DEAL_x state SHALL load the current card source value into its card register on the edge leaving it.
REQ-016 DEAL_P1->DEAL_B1->DEAL_P2->DEAL_B2->EVAL unconditionally.
REQ-017 EVAL: pscore>=8 or bscore>=8 -> DONE; else pscore<=5 -> DEAL_P3; else bscore<=5 -> DEAL_B3; else DONE.
REQ-018 DEAL_P3 -> BANK_DEC; BANK_DEC SHALL use p3 = face value of pcard3.
REQ-019 BANK_DEC draws (-> DEAL_B3) when: bscore 0..2; bscore 3 and p3!=8; bscore 4 and p3 in 2..7; bscore 5 and p3 in 4..7; bscore 6 and p3 in 6..7; otherwise (incl. bscore 7) -> DONE.
REQ-020 DEAL_B3 -> DONE.
REQ-021 Latency from the edge sampling start to the edge entering DONE: 5 edges (no draws), 6 (banker only), 7 (player only), 8 (both).
REQ-022 DONE SHALL hold until start or reset; player_win = pscore>bscore or tie, banker_win = bscore>pscore or tie; both 0 outside DONE.
REQ-023 start in any state other than IDLE/DONE SHALL be ignored.
REQ-024 Internal card source: 4-bit counter, free-running every cycle in all states, sequence 1..13, 13 wraps to 1.

Reset
REQ-025 reset SHALL immediately force state IDLE, all card registers 0, counter 1, done/busy/player_win/banker_win 0, regardless of state (including mid-deal).
REQ-026 pscore and bscore SHALL therefore read 0 during and after reset.

Configuration
REQ-027 DEALER_EXT_CARD_EN defined: ext_card port exists and DEAL_x states load ext_card instead of the counter; counter still present but unused.
REQ-028 DEALER_EXT_CARD_EN undefined: no ext_card port; cards come from the internal counter per REQ-024.

Structure
REQ-029 Shared package card_pkg SHALL hold the state enum typedef, card/score typedefs (4-bit), and constants NATURAL_MIN=8, DRAW_MAX=5, CARD_MAX=13.
REQ-030 One sub-module hand_value SHALL compute one hand score from three cards; instantiated twice (player, banker).

Verification (bench built with DEALER_EXT_CARD_EN)
REQ-031 Natural: ext cards 4,2,4,3 -> pscore=8, bscore=5, DONE 5 edges after start, pcard3=bcard3=0, player_win=1, banker_win=0.
REQ-032 Bank 6 draws on p3=7: cards 3,2,2,4,7,1 -> pcard3=7, bcard3=1, pscore=2, bscore=7, banker_win=1, done at 8 edges.
REQ-033 Bank 6 stands on p3=8: cards 1,3,1,3,8 -> pcard3=8, bcard3=0, pscore=0, bscore=6, banker_win=1, done at 7 edges.
REQ-034 Player stands, banker draws: cards 13,2,6,3,1 -> pscore=6, bcard3=1, bscore=6, player_win=banker_win=1 (tie), done at 6 edges.
REQ-035 Reset mid-game: assert reset in DEAL_P2 -> all outputs 0 asynchronously, busy=0; after release, start deals cleanly.
REQ-036 Handshake: start pulsed during DEAL_B1 ignored; start in DONE clears cards and reaches DEAL_P1 next edge; counter mode (macro off) cycles 1..13 with wrap 13->1.

Source files
------------

// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared types, constants and card face helper for the baccarat dealer
//
// Purpose: holds the dealer state enum, 4-bit card/score typedefs, the rule
// thresholds and the face-value helper used by the score and draw logic.
// Ports: none (package).

package card_pkg;

  typedef logic [3:0] card_t;
  typedef logic [3:0] score_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEAL_P1,
    ST_DEAL_B1,
    ST_DEAL_P2,
    ST_DEAL_B2,
    ST_EVAL,
    ST_DEAL_P3,
    ST_BANK_DEC,
    ST_DEAL_B3,
    ST_DONE
  } state_t;

  localparam score_t NATURAL_MIN = 4'd8;
  localparam score_t DRAW_MAX    = 4'd5;
  localparam card_t  CARD_MAX    = 4'd13;

  // 1..9 count at face value; 0 (not dealt) and 10..13 (tens, court cards)
  // as well as the unused codes 14..15 count as zero.
  function automatic card_t face_value(input card_t c);
    return ((c >= 4'd1) && (c <= 4'd9)) ? c : 4'd0;
  endfunction

endpackage

// File: rtl/hand_value.sv
// rtl/hand_value.sv - baccarat score of one three-card hand
//
// Purpose: sums the face values of three card registers at 5-bit width and
// reduces the sum modulo 10.
// Ports:
//   card1_i, card2_i, card3_i  in   4  card codes (0 = not dealt)
//   score_o                    out  4  hand score 0..9

module hand_value
  import card_pkg::*;
(
  input  card_t  card1_i,
  input  card_t  card2_i,
  input  card_t  card3_i,
  output score_t score_o
);

  logic [4:0] sum;
  logic [4:0] rem;

  assign sum     = {1'b0, face_value(card1_i)} + {1'b0, face_value(card2_i)}
                 + {1'b0, face_value(card3_i)};
  assign rem     = sum % 5'd10;
  assign score_o = rem[3:0];

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - baccarat dealing and tableau sequencer
//
// Purpose: on start, clears the table and deals two cards each to player and
// banker, then applies the third-card tableau and reports the winner.
// Configuration macro: DEALER_EXT_CARD_EN - when defined, the ext_card port
// exists and supplies every dealt card; otherwise a free-running 1..13
// counter supplies them.
// Ports:
//   clk                    in   1  clock, rising edge
//   reset                  in   1  asynchronous active-high reset
//   start                  in   1  new game request (honoured in IDLE/DONE)
//   ext_card               in   4  external card source (macro only)
//   pcard1..pcard3         out  4  player cards (0 = not dealt)
//   bcard1..bcard3         out  4  banker cards (0 = not dealt)
//   pscore, bscore         out  4  hand scores 0..9
//   player_win, banker_win out  1  result, both high on tie, only in DONE
//   done                   out  1  game finished
//   busy                   out  1  dealing or evaluating

module card_dealer
  import card_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
`ifdef DEALER_EXT_CARD_EN
  input  logic [3:0] ext_card,
`endif
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] bcard1,
  output logic [3:0] bcard2,
  output logic [3:0] bcard3,
  output logic [3:0] pscore,
  output logic [3:0] bscore,
  output logic       player_win,
  output logic       banker_win,
  output logic       done,
  output logic       busy
);

  state_t state_q, state_d;
  card_t  pcard1_q, pcard1_d, pcard2_q, pcard2_d, pcard3_q, pcard3_d;
  card_t  bcard1_q, bcard1_d, bcard2_q, bcard2_d, bcard3_q, bcard3_d;
  card_t  cnt_q;
  card_t  card_src;
  card_t  p3;
  logic   bank_draw;

  // The counter keeps running in every state so the dealt sequence depends
  // on when start arrives, not only on how many cards were dealt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd1;
    end else if (cnt_q == CARD_MAX) begin
      cnt_q <= 4'd1;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

`ifdef DEALER_EXT_CARD_EN
  assign card_src = ext_card;
`else
  assign card_src = cnt_q;
`endif

  hand_value u_player_hand (
    .card1_i (pcard1_q),
    .card2_i (pcard2_q),
    .card3_i (pcard3_q),
    .score_o (pscore)
  );

  hand_value u_banker_hand (
    .card1_i (bcard1_q),
    .card2_i (bcard2_q),
    .card3_i (bcard3_q),
    .score_o (bscore)
  );

  // Banker tableau after the player has taken a third card.
  assign p3 = face_value(pcard3_q);

  always_comb begin
    bank_draw = 1'b0;
    case (bscore)
      4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
      4'd3:             bank_draw = (p3 != 4'd8);
      4'd4:             bank_draw = (p3 >= 4'd2) && (p3 <= 4'd7);
      4'd5:             bank_draw = (p3 >= 4'd4) && (p3 <= 4'd7);
      4'd6:             bank_draw = (p3 >= 4'd6) && (p3 <= 4'd7);
      default:          bank_draw = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pcard1_d = pcard1_q;
    pcard2_d = pcard2_q;
    pcard3_d = pcard3_q;
    bcard1_d = bcard1_q;
    bcard2_d = bcard2_q;
    bcard3_d = bcard3_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pcard1_d = 4'd0;
          pcard2_d = 4'd0;
          pcard3_d = 4'd0;
          bcard1_d = 4'd0;
          bcard2_d = 4'd0;
          bcard3_d = 4'd0;
          state_d  = ST_DEAL_P1;
        end
      end
      ST_DEAL_P1: begin pcard1_d = card_src; state_d = ST_DEAL_B1; end
      ST_DEAL_B1: begin bcard1_d = card_src; state_d = ST_DEAL_P2; end
      ST_DEAL_P2: begin pcard2_d = card_src; state_d = ST_DEAL_B2; end
      ST_DEAL_B2: begin bcard2_d = card_src; state_d = ST_EVAL;    end
      ST_EVAL: begin
        if ((pscore >= NATURAL_MIN) || (bscore >= NATURAL_MIN)) begin
          state_d = ST_DONE;
        end else if (pscore <= DRAW_MAX) begin
          state_d = ST_DEAL_P3;
        end else if (bscore <= DRAW_MAX) begin
          state_d = ST_DEAL_B3;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DEAL_P3:  begin pcard3_d = card_src; state_d = ST_BANK_DEC; end
      ST_BANK_DEC: state_d = bank_draw ? ST_DEAL_B3 : ST_DONE;
      ST_DEAL_B3:  begin bcard3_d = card_src; state_d = ST_DONE; end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pcard1_q <= 4'd0;
      pcard2_q <= 4'd0;
      pcard3_q <= 4'd0;
      bcard1_q <= 4'd0;
      bcard2_q <= 4'd0;
      bcard3_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      pcard1_q <= pcard1_d;
      pcard2_q <= pcard2_d;
      pcard3_q <= pcard3_d;
      bcard1_q <= bcard1_d;
      bcard2_q <= bcard2_d;
      bcard3_q <= bcard3_d;
    end
  end

  assign pcard1     = pcard1_q;
  assign pcard2     = pcard2_q;
  assign pcard3     = pcard3_q;
  assign bcard1     = bcard1_q;
  assign bcard2     = bcard2_q;
  assign bcard3     = bcard3_q;
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign player_win = done && (pscore >= bscore);
  assign banker_win = done && (bscore >= pscore);

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - scoreboard bench for card_dealer (external-card or counter build)

module tb_card_dealer;

  typedef struct {
    int pc1, pc2, pc3, bc1, bc2, bc3;
    int ps, bs, pw, bw, lat;
    int start_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] ext_card;
  logic [3:0] pcard1, pcard2, pcard3, bcard1, bcard2, bcard3;
  logic [3:0] pscore, bscore;
  logic       player_win, banker_win, done, busy;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic done_prev = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;

  card_dealer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef DEALER_EXT_CARD_EN
    .ext_card   (ext_card),
`endif
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .bcard1     (bcard1),
    .bcard2     (bcard2),
    .bcard3     (bcard3),
    .pscore     (pscore),
    .bscore     (bscore),
    .player_win (player_win),
    .banker_win (banker_win),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input int pc1, pc2, pc3, bc1, bc2, bc3,
                              input int ps, bs, pw, bw, lat);
    exp_t e;
    e.pc1 = pc1; e.pc2 = pc2; e.pc3 = pc3;
    e.bc1 = bc1; e.bc2 = bc2; e.bc3 = bc3;
    e.ps = ps; e.bs = bs; e.pw = pw; e.bw = bw; e.lat = lat;
    e.start_cyc = 0;
    return e;
  endfunction

  // Monitor: every rising edge of done consumes one expected game.
  always @(negedge clk) begin
    if (reset) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("pcard1", int'(pcard1), mon_e.pc1);
          chk("pcard2", int'(pcard2), mon_e.pc2);
          chk("pcard3", int'(pcard3), mon_e.pc3);
          chk("bcard1", int'(bcard1), mon_e.bc1);
          chk("bcard2", int'(bcard2), mon_e.bc2);
          chk("bcard3", int'(bcard3), mon_e.bc3);
          chk("pscore", int'(pscore), mon_e.ps);
          chk("bscore", int'(bscore), mon_e.bs);
          chk("player_win", int'(player_win), mon_e.pw);
          chk("banker_win", int'(banker_win), mon_e.bw);
          chk("latency", cyc - mon_e.start_cyc, mon_e.lat);
          chk("busy_in_done", int'(busy), 0);
        end
      end
      done_prev = done;
    end
  end

  // tab holds the ext_card value for each cycle after the start edge,
  // first cycle in the top nibble; idle slots are zero.
  task automatic run_game(input logic [31:0] tab, input exp_t e, input bit pulse_b1);
    bit got;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    chk("clr_pcard1", int'(pcard1), 0);
    chk("clr_bcard3", int'(bcard3), 0);
    chk("start_busy", int'(busy), 1);
    chk("start_done", int'(done), 0);
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!got) begin
        ext_card = tab[31-4*k -: 4];
        start    = (pulse_b1 && (k == 1)) ? 1'b1 : 1'b0;
        @(posedge clk);
        #1;
        if (done) got = 1'b1;
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic reset_zero_checks(input string tag);
    chk({tag, "_pcard1"}, int'(pcard1), 0);
    chk({tag, "_bcard1"}, int'(bcard1), 0);
    chk({tag, "_pcard2"}, int'(pcard2), 0);
    chk({tag, "_pscore"}, int'(pscore), 0);
    chk({tag, "_bscore"}, int'(bscore), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pwin"}, int'(player_win), 0);
    chk({tag, "_bwin"}, int'(banker_win), 0);
  endtask

  task automatic mid_game_reset();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ext_card = 4'd4;
    @(posedge clk);
    #1 ext_card = 4'd2;
    @(posedge clk);
    #3;
    chk("pre_rst_pcard1_nz", int'(pcard1 != 4'd0), 1);
    chk("pre_rst_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    reset_zero_checks("midrst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    ext_card = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_zero_checks("rst");
    @(negedge clk);
    reset = 1'b0;
`ifdef DEALER_EXT_CARD_EN
    // natural, with a start pulse in DEAL_B1 that must be ignored
    run_game(32'h4243_0000, mk(4, 4, 0, 2, 3, 0, 8, 5, 1, 0, 5), 1'b1);
    // restart from DONE: bank 6 draws on p3=7
    run_game(32'h3224_0701, mk(3, 2, 7, 2, 4, 1, 2, 7, 0, 1, 8), 1'b0);
    // bank 6 stands on p3=8
    run_game(32'h1313_0800, mk(1, 1, 8, 3, 3, 0, 0, 6, 0, 1, 7), 1'b0);
    mid_game_reset();
    // player stands on 6, banker draws from 5, tie
    run_game(32'hD263_0100, mk(13, 6, 0, 2, 3, 1, 6, 6, 1, 1, 6), 1'b0);
`else
    // counter is 11 at the start edge: cards 12,13,1,2 then 4 and 6 (wraps)
    repeat (10) @(posedge clk);
    #1;
    run_game(32'h0, mk(12, 1, 4, 13, 2, 6, 5, 8, 0, 1, 8), 1'b1);
    // restart immediately from DONE: counter 7 at start edge, cards 8..11
    run_game(32'h0, mk(8, 10, 0, 9, 11, 0, 8, 9, 0, 1, 5), 1'b0);
    mid_game_reset();
    // start on the first edge after reset release: cards 2,3,4,5
    run_game(32'h0, mk(2, 4, 0, 3, 5, 0, 6, 8, 0, 1, 5), 1'b0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
